// File: rtl/decode_lane_merger_pkg.sv
// Shared decode definitions: functional-unit IDs, opcode width and payload field
// offsets, plus sizing helpers for the lane merger.
package decode_lane_merger_pkg;

  localparam int unsigned OPCODE_W = 8;
  localparam int unsigned UNIT_W   = 3;

  typedef enum logic [UNIT_W-1:0] {
    UNIT_ALU = 3'd0,
    UNIT_MUL = 3'd1,
    UNIT_DIV = 3'd2,
    UNIT_LSU = 3'd3,
    UNIT_BRU = 3'd4,
    UNIT_FPU = 3'd5
  } unit_e;

  // Field layout inside the decoded-uop bundle; the merger never looks inside.
  localparam int unsigned PAYLOAD_OPCODE_LSB = 0;
  localparam int unsigned PAYLOAD_UNIT_LSB   = PAYLOAD_OPCODE_LSB + OPCODE_W;
  localparam int unsigned PAYLOAD_ADDR_LSB   = PAYLOAD_UNIT_LSB + UNIT_W;
  localparam int unsigned PAYLOAD_BODY_LSB   = PAYLOAD_ADDR_LSB + 64;

  function automatic int unsigned lane_count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/decode_lane_fifo.sv
// Circular buffer for one decoder lane; push and pop may coincide at any
// occupancy, including full.
module decode_lane_fifo
  import decode_lane_merger_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = lane_count_width(DEPTH)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // When full, the slot under wr_ptr is the head being popped this cycle.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock_i) begin
    if (reset_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i && !flush && do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/decode_lane_merger.sv
// Merges two decoder lanes into one in-order uop stream, oldest major ID first,
// with per-lane buffering, early stall and a sticky overflow flag.
module decode_lane_merger
  import decode_lane_merger_pkg::*;
#(
  parameter int unsigned instructionCounterWidth = 64,
  parameter int unsigned payloadWidth            = 128,
  parameter int unsigned laneDepth               = 4
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               flush_i,
  input  logic                               lane0Enable_i,
  input  logic                               lane1Enable_i,
  input  logic [instructionCounterWidth-1:0] lane0MajId_i,
  input  logic [instructionCounterWidth-1:0] lane1MajId_i,
  input  logic [payloadWidth-1:0]            lane0Payload_i,
  input  logic [payloadWidth-1:0]            lane1Payload_i,
  output logic                               lane0Stall_o,
  output logic                               lane1Stall_o,
  input  logic                               ready_i,
  output logic                               enable_o,
  output logic [instructionCounterWidth-1:0] majId_o,
  output logic [payloadWidth-1:0]            payload_o,
  output logic                               laneSel_o,
  output logic                               overflow_o
);

  localparam int unsigned ENTRY_W = instructionCounterWidth + payloadWidth;
  localparam int unsigned CNT_W   = lane_count_width(laneDepth);

  logic [ENTRY_W-1:0]                 lane0_head, lane1_head;
  logic [CNT_W-1:0]                   lane0_count, lane1_count;
  logic                               lane0_full, lane1_full;
  logic                               lane0_empty, lane1_empty;
  logic                               lane0_pop, lane1_pop;
  logic                               sel_lane1;
  logic                               present;
  logic [instructionCounterWidth-1:0] lane0_maj, lane1_maj;

  decode_lane_fifo #(.DEPTH(laneDepth), .WIDTH(ENTRY_W)) u_lane0 (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .flush   (flush_i),
    .push    (lane0Enable_i),
    .pop     (lane0_pop),
    .wr_data ({lane0MajId_i, lane0Payload_i}),
    .rd_data (lane0_head),
    .count   (lane0_count),
    .full    (lane0_full),
    .empty   (lane0_empty)
  );

  decode_lane_fifo #(.DEPTH(laneDepth), .WIDTH(ENTRY_W)) u_lane1 (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .flush   (flush_i),
    .push    (lane1Enable_i),
    .pop     (lane1_pop),
    .wr_data ({lane1MajId_i, lane1Payload_i}),
    .rd_data (lane1_head),
    .count   (lane1_count),
    .full    (lane1_full),
    .empty   (lane1_empty)
  );

  assign lane0_maj = lane0_head[ENTRY_W-1 -: instructionCounterWidth];
  assign lane1_maj = lane1_head[ENTRY_W-1 -: instructionCounterWidth];

  // One slot stays free for the uop already leaving the registered decoder.
  assign lane0Stall_o = (lane0_count >= CNT_W'(laneDepth - 1));
  assign lane1Stall_o = (lane1_count >= CNT_W'(laneDepth - 1));

  assign present   = !lane0_empty || !lane1_empty;
  assign sel_lane1 = !lane1_empty && (lane0_empty || (lane1_maj < lane0_maj));
  assign lane0_pop = present && ready_i && !sel_lane1;
  assign lane1_pop = present && ready_i && sel_lane1;

  always_comb begin
    enable_o  = present;
    laneSel_o = 1'b0;
    majId_o   = '0;
    payload_o = '0;
    if (present) begin
      laneSel_o = sel_lane1;
      majId_o   = sel_lane1 ? lane1_maj : lane0_maj;
      payload_o = sel_lane1 ? lane1_head[payloadWidth-1:0] : lane0_head[payloadWidth-1:0];
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      overflow_o <= 1'b0;
    end else if (!flush_i && ((lane0Enable_i && lane0_full && !lane0_pop) ||
                              (lane1Enable_i && lane1_full && !lane1_pop))) begin
      overflow_o <= 1'b1;
    end
  end

endmodule
